// File: rtl/soc_ahb4_pkg.sv
// Shared AHB4-Lite encodings and responder FSM type for the external-port responder.
package soc_ahb4_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_BUSY   = 2'd1;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] HTRANS_SEQ    = 2'd3;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HWORD = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ERR1,
        ST_ERR2
    } responder_state_t;

    // Little-endian lane enables for a transfer of the given size and low address bits.
    function automatic logic [3:0] byte_enables(input logic [2:0] size, input logic [1:0] addr_lo);
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            HSIZE_BYTE:  be = 4'b0001 << addr_lo;
            HSIZE_HWORD: be = addr_lo[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD:  be = 4'b1111;
            default:     be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/soc_ahb4_responder_ram.sv
// Word-organised backing store: one shared index, byte-enable write, asynchronous read.
module soc_ahb4_responder_ram #(
    parameter int MEM_DEPTH = 1024,
    localparam int AW = $clog2(MEM_DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [3:0]    i_be,
    input  logic [AW-1:0] i_idx,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < 4; b++) begin
                if (i_be[b]) begin
                    r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/soc_ahb4_ext_responder.sv
// AHB4-Lite slave backing the tile's external port with a small RAM, optional wait
// states and an address window that always answers ERROR.
module soc_ahb4_ext_responder
    import soc_ahb4_pkg::*;
#(
    parameter int               PLEN        = 32,
    parameter int               XLEN        = 32,
    parameter int               MEM_DEPTH   = 1024,
    parameter int               WAIT_STATES = 0,
    parameter logic [PLEN-1:0]  ERR_BASE    = 32'hFFFF_F000,
    parameter logic [PLEN-1:0]  ERR_SIZE    = 32'h1000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ahb4_hsel_i,
    input  logic [PLEN-1:0] ahb4_haddr_i,
    input  logic [XLEN-1:0] ahb4_hwdata_i,
    input  logic            ahb4_hwrite_i,
    input  logic [2:0]      ahb4_hsize_i,
    input  logic [2:0]      ahb4_hburst_i,
    input  logic [3:0]      ahb4_hprot_i,
    input  logic [1:0]      ahb4_htrans_i,
    input  logic            ahb4_hmastlock_i,
    input  logic            ahb4_hready_i,
    output logic [XLEN-1:0] ahb4_hrdata_o,
    output logic            ahb4_hreadyout_o,
    output logic            ahb4_hresp_o
);

    localparam int         IDX_W     = $clog2(MEM_DEPTH);
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES - 1);

    responder_state_t r_state;
    logic [3:0]       r_cnt;
    logic             r_pend;
    logic             r_write;
    logic [IDX_W-1:0] r_idx;
    logic [3:0]       r_be;
    logic             r_hreadyout;
    logic             r_hresp;

    logic             w_active;
    logic             w_accept;
    logic             w_size_err;
    logic             w_align_err;
    logic             w_win_err;
    logic             w_err;
    logic [PLEN-1:0]  w_win_off;
    logic             w_commit;
    logic [31:0]      w_ram_rdata;
    logic             w_unused;

    assign w_unused = ^{ahb4_hburst_i, ahb4_hprot_i, ahb4_hmastlock_i};

    assign w_active = (ahb4_htrans_i == HTRANS_NONSEQ) || (ahb4_htrans_i == HTRANS_SEQ);
    assign w_accept = ahb4_hsel_i && ahb4_hready_i && w_active;

    assign w_size_err  = ahb4_hsize_i > HSIZE_WORD;
    assign w_align_err = ((ahb4_hsize_i == HSIZE_HWORD) && ahb4_haddr_i[0]) ||
                         ((ahb4_hsize_i == HSIZE_WORD) && (ahb4_haddr_i[1:0] != 2'b00));
    // Offset compare handles a window that ends exactly at the top of the address space.
    assign w_win_off = ahb4_haddr_i - ERR_BASE;
    assign w_win_err = (ERR_SIZE != '0) && (w_win_off < ERR_SIZE);
    assign w_err     = w_size_err || w_align_err || w_win_err;

    // The data phase completes on any edge where hreadyout is high with an OKAY transfer pending.
    assign w_commit = r_hreadyout && r_pend && r_write && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_pend      <= 1'b0;
            r_write     <= 1'b0;
            r_idx       <= '0;
            r_be        <= '0;
            r_hreadyout <= 1'b1;
            r_hresp     <= HRESP_OKAY;
        end else begin
            case (r_state)
                ST_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state     <= ST_IDLE;
                        r_hreadyout <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_ERR1: begin
                    r_state     <= ST_ERR2;
                    r_hreadyout <= 1'b1;
                    r_hresp     <= HRESP_ERROR;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_pend      <= 1'b0;
                    r_hreadyout <= 1'b1;
                    r_hresp     <= HRESP_OKAY;
                    if (w_accept) begin
                        r_write <= ahb4_hwrite_i;
                        r_idx   <= ahb4_haddr_i[IDX_W+1:2];
                        r_be    <= byte_enables(ahb4_hsize_i, ahb4_haddr_i[1:0]);
                        if (w_err) begin
                            r_state     <= ST_ERR1;
                            r_hreadyout <= 1'b0;
                            r_hresp     <= HRESP_ERROR;
                        end else begin
                            r_pend <= 1'b1;
                            if (WAIT_STATES > 0) begin
                                r_state     <= ST_WAIT;
                                r_cnt       <= WAIT_LOAD;
                                r_hreadyout <= 1'b0;
                            end
                        end
                    end
                end
            endcase
        end
    end

    soc_ahb4_responder_ram #(
        .MEM_DEPTH (MEM_DEPTH)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_commit),
        .i_be    (r_be),
        .i_idx   (r_idx),
        .i_wdata (ahb4_hwdata_i),
        .o_rdata (w_ram_rdata)
    );

    assign ahb4_hrdata_o    = (r_pend && !r_write) ? w_ram_rdata : '0;
    assign ahb4_hreadyout_o = r_hreadyout;
    assign ahb4_hresp_o     = r_hresp;

endmodule

// File: tb/tb_soc_ahb4_ext_responder.sv
// Directed bench for the external-port responder: two instances (0 and 3 wait states)
// on a shared pipelined master, with a queue of expected completions.
module tb_soc_ahb4_ext_responder;
    import soc_ahb4_pkg::*;

    typedef struct {
        string       tag;
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_resp;
        int          exp_waits;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        tgt;
    logic        m_hsel;
    logic [31:0] m_haddr;
    logic [31:0] m_hwdata;
    logic        m_hwrite;
    logic [2:0]  m_hsize;
    logic [2:0]  m_hburst;
    logic [3:0]  m_hprot;
    logic [1:0]  m_htrans;
    logic        m_hmastlock;

    logic [31:0] rd0, rd3;
    logic        rdy0, rdy3, rsp0, rsp3;
    logic        bus_hready;
    logic [31:0] bus_rdata;
    logic        bus_resp;

    int checks   = 0;
    int failures = 0;

    txn_t req_q[$];
    txn_t exp_q[$];

    always #5 clk = ~clk;

    assign bus_hready = tgt ? rdy3 : rdy0;
    assign bus_rdata  = tgt ? rd3  : rd0;
    assign bus_resp   = tgt ? rsp3 : rsp0;

    soc_ahb4_ext_responder #(.WAIT_STATES(0)) u_dut0 (
        .clk              (clk),
        .rst              (rst),
        .ahb4_hsel_i      (m_hsel && !tgt),
        .ahb4_haddr_i     (m_haddr),
        .ahb4_hwdata_i    (m_hwdata),
        .ahb4_hwrite_i    (m_hwrite),
        .ahb4_hsize_i     (m_hsize),
        .ahb4_hburst_i    (m_hburst),
        .ahb4_hprot_i     (m_hprot),
        .ahb4_htrans_i    (m_htrans),
        .ahb4_hmastlock_i (m_hmastlock),
        .ahb4_hready_i    (bus_hready),
        .ahb4_hrdata_o    (rd0),
        .ahb4_hreadyout_o (rdy0),
        .ahb4_hresp_o     (rsp0)
    );

    soc_ahb4_ext_responder #(.WAIT_STATES(3)) u_dut3 (
        .clk              (clk),
        .rst              (rst),
        .ahb4_hsel_i      (m_hsel && tgt),
        .ahb4_haddr_i     (m_haddr),
        .ahb4_hwdata_i    (m_hwdata),
        .ahb4_hwrite_i    (m_hwrite),
        .ahb4_hsize_i     (m_hsize),
        .ahb4_hburst_i    (m_hburst),
        .ahb4_hprot_i     (m_hprot),
        .ahb4_htrans_i    (m_htrans),
        .ahb4_hmastlock_i (m_hmastlock),
        .ahb4_hready_i    (bus_hready),
        .ahb4_hrdata_o    (rd3),
        .ahb4_hreadyout_o (rdy3),
        .ahb4_hresp_o     (rsp3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic add(input string tag, input logic wr, input logic [31:0] addr,
                       input logic [2:0] size, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_resp, input int exp_waits);
        txn_t t;
        t.tag = tag; t.wr = wr; t.addr = addr; t.size = size; t.wdata = wdata;
        t.exp_rdata = exp_rdata; t.exp_resp = exp_resp; t.exp_waits = exp_waits;
        req_q.push_back(t);
    endtask

    task automatic drive_idle();
        m_hsel   = 1'b0;
        m_htrans = HTRANS_IDLE;
        m_hwrite = 1'b0;
        m_hsize  = HSIZE_WORD;
        m_haddr  = 32'h0;
    endtask

    // Pipelined master: runs from one falling edge to the next, drives the next address
    // whenever the bus is ready, and pops the expected completion when the data phase ends.
    task automatic run_q();
        int   cyc = 0;
        bit   ap_valid = 1'b0;
        int   low = 0;
        txn_t t;
        while ((req_q.size() > 0 || exp_q.size() > 0) && cyc < 200) begin
            if (ap_valid) begin
                ap_valid = 1'b0;
                m_hwdata = exp_q[0].wdata;
                low      = 0;
            end
            if (exp_q.size() > 0) begin
                if (!bus_hready) begin
                    low++;
                    check({exp_q[0].tag, "_stall_resp"}, bus_resp, exp_q[0].exp_resp);
                end else begin
                    t = exp_q.pop_front();
                    check({t.tag, "_resp"},  bus_resp, t.exp_resp);
                    check({t.tag, "_rdata"}, bus_rdata, t.exp_rdata);
                    check({t.tag, "_waits"}, 32'(low), 32'(t.exp_waits));
                end
            end
            if (bus_hready && req_q.size() > 0) begin
                t = req_q.pop_front();
                m_hsel   = 1'b1;
                m_haddr  = t.addr;
                m_hwrite = t.wr;
                m_hsize  = t.size;
                m_htrans = t.wr ? HTRANS_NONSEQ : HTRANS_SEQ;
                exp_q.push_back(t);
                ap_valid = 1'b1;
            end else begin
                drive_idle();
            end
            @(negedge clk);
            cyc++;
        end
        check("seq_timeout", 32'(req_q.size() + exp_q.size()), 32'd0);
        req_q.delete();
        exp_q.delete();
        drive_idle();
    endtask

    initial begin
        rst         = 1'b1;
        tgt         = 1'b0;
        m_hwdata    = 32'h0;
        m_hburst    = 3'd0;
        m_hprot     = 4'd0;
        m_hmastlock = 1'b0;
        drive_idle();

        for (int i = 0; i < 3; i++) begin
            m_hsel   = 1'($urandom);
            m_haddr  = $urandom;
            m_hwdata = $urandom;
            m_hwrite = 1'($urandom);
            m_hsize  = 3'($urandom_range(0, 7));
            m_htrans = 2'($urandom_range(0, 3));
            m_hburst = 3'($urandom);
            m_hprot  = 4'($urandom);
            @(negedge clk);
            check("rst_rdy0", rdy0, 1'b1);
            check("rst_rsp0", rsp0, HRESP_OKAY);
            check("rst_rd0",  rd0,  32'h0);
            check("rst_rdy3", rdy3, 1'b1);
            check("rst_rsp3", rsp3, HRESP_OKAY);
            check("rst_rd3",  rd3,  32'h0);
        end
        drive_idle();
        m_hburst = 3'd0;
        m_hprot  = 4'd0;
        rst      = 1'b0;

        add("wr_deadbeef", 1, 32'h10, HSIZE_WORD, 32'hDEADBEEF, 32'h0, HRESP_OKAY, 0);
        add("rd_deadbeef", 0, 32'h10, HSIZE_WORD, 32'h0, 32'hDEADBEEF, HRESP_OKAY, 0);
        add("wr_11223344", 1, 32'h10, HSIZE_WORD, 32'h11223344, 32'h0, HRESP_OKAY, 0);
        add("wr_byte13",   1, 32'h13, HSIZE_BYTE, 32'h5A000000, 32'h0, HRESP_OKAY, 0);
        add("rd_byte13",   0, 32'h10, HSIZE_WORD, 32'h0, 32'h5A223344, HRESP_OKAY, 0);
        add("wr_aabbccdd", 1, 32'h14, HSIZE_WORD, 32'hAABBCCDD, 32'h0, HRESP_OKAY, 0);
        add("wr_half16",   1, 32'h16, HSIZE_HWORD, 32'h12340000, 32'h0, HRESP_OKAY, 0);
        add("rd_half16",   0, 32'h14, HSIZE_HWORD, 32'h0, 32'h1234CCDD, HRESP_OKAY, 0);
        add("wr_pre04",    1, 32'h04, HSIZE_WORD, 32'hCAFEF00D, 32'h0, HRESP_OKAY, 0);
        add("wr_errwin",   1, 32'hFFFFF004, HSIZE_WORD, 32'h12345678, 32'h0, HRESP_ERROR, 1);
        add("rd_alias04",  0, 32'h04, HSIZE_WORD, 32'h0, 32'hCAFEF00D, HRESP_OKAY, 0);
        add("rd_misal_w",  0, 32'h02, HSIZE_WORD, 32'h0, 32'h0, HRESP_ERROR, 1);
        add("rd_size3",    0, 32'h08, 3'd3, 32'h0, 32'h0, HRESP_ERROR, 1);
        add("rd_misal_h",  0, 32'h01, HSIZE_HWORD, 32'h0, 32'h0, HRESP_ERROR, 1);
        add("rd_after_err",0, 32'h10, HSIZE_WORD, 32'h0, 32'h5A223344, HRESP_OKAY, 0);
        run_q();

        tgt = 1'b1;
        add("w3_wr20",     1, 32'h20, HSIZE_WORD, 32'hA5A50020, 32'h0, HRESP_OKAY, 3);
        add("w3_rd20",     0, 32'h20, HSIZE_WORD, 32'h0, 32'hA5A50020, HRESP_OKAY, 3);
        add("w3_misal",    0, 32'h02, HSIZE_WORD, 32'h0, 32'h0, HRESP_ERROR, 1);
        run_q();

        m_hsel   = 1'b1;
        m_haddr  = 32'h20;
        m_hwrite = 1'b1;
        m_hsize  = HSIZE_WORD;
        m_htrans = HTRANS_NONSEQ;
        @(negedge clk);
        drive_idle();
        m_hwdata = 32'hBAD0BAD0;
        check("mr_in_wait", rdy3, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("mr_rdy", rdy3, 1'b1);
        check("mr_rsp", rsp3, HRESP_OKAY);
        check("mr_rd",  rd3,  32'h0);
        rst = 1'b0;
        m_hwdata = 32'h0;
        @(negedge clk);
        check("mr_idle_rdy", rdy3, 1'b1);
        add("mr_rd20", 0, 32'h20, HSIZE_WORD, 32'h0, 32'hA5A50020, HRESP_OKAY, 3);
        run_q();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
